// File: rtl/sdram_mem_bist_pkg.sv
// Shared types and constants for the SDRAM memory self-test engine:
// sequencer states, ramio request encodings, pattern ids and LFSR taps.
package sdram_mem_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRITE_WAIT,
        READ,
        READ_WAIT,
        NEXT_PATTERN,
        DONE
    } state_t;

    localparam logic [1:0] WriteWord = 2'b11;
    localparam logic [1:0] WriteNone = 2'b00;
    localparam logic [2:0] ReadWord  = 3'b111;
    localparam logic [2:0] ReadNone  = 3'b000;

    localparam logic [1:0] PatAddress    = 2'd0;
    localparam logic [1:0] PatInvAddress = 2'd1;
    localparam logic [1:0] PatLfsr       = 2'd2;
    localparam logic [1:0] PatWalkingOne = 2'd3;

    // Galois form of the x^32 + x^22 + x^2 + x + 1 polynomial, right-shifting
    localparam logic [31:0] LfsrTaps = 32'h8020_0003;

    localparam logic [2:0] NoPattern = 3'd4;

    // Lowest set mask bit at or above position 'from'; NoPattern if none.
    function automatic logic [2:0] next_set(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] found;
        found = NoPattern;
        for (int k = 3; k >= 0; k--) begin
            if (mask[k] && (3'(k) >= from)) begin
                found = 3'(k);
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/sdram_mem_bist_pattern_gen.sv
// Test-data generator shared by the write and read phases, so the read
// phase reproduces exactly what was written for the same word.
module bist_pattern_gen
    import sdram_mem_bist_pkg::*;
(
    input  logic [1:0]  pattern,
    input  logic [4:0]  word_pos,
    input  logic [31:0] address,
    input  logic [31:0] lfsr,
    output logic [31:0] data,
    output logic [31:0] lfsr_next
);

    always_comb begin
        lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LfsrTaps : 32'h0);
    end

    always_comb begin
        data = address;
        case (pattern)
            PatAddress:    data = address;
            PatInvAddress: data = ~address;
            PatLfsr:       data = lfsr;
            PatWalkingOne: data = 32'd1 << word_pos;
            default:       data = address;
        endcase
    end

endmodule

// File: rtl/sdram_mem_bist.sv
// Memory self-test sequencer: writes then reads back a word range on the
// ramio interface for each enabled pattern and records mismatches.
module sdram_mem_bist
    import sdram_mem_bist_pkg::*;
#(
    parameter logic [31:0] BaseAddress        = 32'h0000_0000,
    parameter int          WordCount          = 1024,
    parameter int          PatternCount       = 4,
    parameter logic [31:0] LfsrSeed           = 32'hACE1_2468,
    parameter int          ErrorCountBitwidth = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [PatternCount-1:0]       pattern_mask,
    output logic                          mem_enable,
    output logic [1:0]                    mem_write_type,
    output logic [2:0]                    mem_read_type,
    output logic [31:0]                   mem_address,
    output logic [31:0]                   mem_data_in,
    input  logic [31:0]                   mem_data_out,
    input  logic                          mem_data_out_ready,
    input  logic                          mem_busy,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [ErrorCountBitwidth-1:0] error_count,
    output logic [31:0]                   first_error_address,
    output logic [31:0]                   first_error_expected,
    output logic [31:0]                   first_error_actual
);

    localparam int IdxW = (WordCount > 1) ? $clog2(WordCount) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WordCount - 1);

    state_t                  state, state_next;
    logic [PatternCount-1:0] mask_r, mask_next;
    logic [1:0]              pat, pat_next;
    logic [IdxW-1:0]         idx, idx_next;
    logic [31:0]             lfsr, lfsr_nx;
    logic                    clear_err, log_err;
    logic                    issue_write, issue_read;
    logic [31:0]             idx_ext, word_addr;
    logic [31:0]             gen_data, gen_lfsr_next;
    logic [2:0]              first_pat, later_pat;

    assign idx_ext   = 32'(idx);
    assign word_addr = BaseAddress + (idx_ext << 2);
    assign first_pat = next_set(4'(pattern_mask), 3'd0);
    assign later_pat = next_set(4'(mask_r), {1'b0, pat} + 3'd1);

    bist_pattern_gen u_pattern_gen (
        .pattern   (pat),
        .word_pos  (idx_ext[4:0]),
        .address   (word_addr),
        .lfsr      (lfsr),
        .data      (gen_data),
        .lfsr_next (gen_lfsr_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        mask_next   = mask_r;
        pat_next    = pat;
        idx_next    = idx;
        lfsr_nx     = lfsr;
        clear_err   = 1'b0;
        log_err     = 1'b0;
        issue_write = 1'b0;
        issue_read  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    mask_next = pattern_mask;
                    clear_err = 1'b1;
                    idx_next  = '0;
                    lfsr_nx   = LfsrSeed;
                    if (first_pat == NoPattern) begin
                        state_next = DONE;
                    end else begin
                        pat_next   = first_pat[1:0];
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                if (!mem_busy) begin
                    issue_write = 1'b1;
                    state_next  = WRITE_WAIT;
                end
            end
            WRITE_WAIT: begin
                if (!mem_busy) begin
                    if (idx == LastIdx) begin
                        idx_next   = '0;
                        lfsr_nx    = LfsrSeed;
                        state_next = READ;
                    end else begin
                        idx_next   = idx + 1'b1;
                        lfsr_nx    = gen_lfsr_next;
                        state_next = WRITE;
                    end
                end
            end
            READ: begin
                if (!mem_busy) begin
                    issue_read = 1'b1;
                    state_next = READ_WAIT;
                end
            end
            READ_WAIT: begin
                if (mem_data_out_ready) begin
                    log_err = (mem_data_out != gen_data);
                    if (idx == LastIdx) begin
                        state_next = NEXT_PATTERN;
                    end else begin
                        idx_next   = idx + 1'b1;
                        lfsr_nx    = gen_lfsr_next;
                        state_next = READ;
                    end
                end
            end
            NEXT_PATTERN: begin
                idx_next = '0;
                lfsr_nx  = LfsrSeed;
                if (later_pat == NoPattern) begin
                    state_next = DONE;
                end else begin
                    pat_next   = later_pat[1:0];
                    state_next = WRITE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_r <= '0;
            pat    <= '0;
            idx    <= '0;
            lfsr   <= LfsrSeed;
        end else begin
            mask_r <= mask_next;
            pat    <= pat_next;
            idx    <= idx_next;
            lfsr   <= lfsr_nx;
        end
    end

    // The counter never returns to zero within a run, so zero marks "no mismatch yet"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_count          <= '0;
            first_error_address  <= '0;
            first_error_expected <= '0;
            first_error_actual   <= '0;
        end else if (clear_err) begin
            error_count          <= '0;
            first_error_address  <= '0;
            first_error_expected <= '0;
            first_error_actual   <= '0;
        end else if (log_err) begin
            if (error_count == '0) begin
                first_error_address  <= word_addr;
                first_error_expected <= gen_data;
                first_error_actual   <= mem_data_out;
            end
            if (error_count != '1) begin
                error_count <= error_count + 1'b1;
            end
        end
    end

    assign mem_enable     = issue_write | issue_read;
    assign mem_write_type = issue_write ? WriteWord : WriteNone;
    assign mem_read_type  = issue_read ? ReadWord : ReadNone;
    assign mem_address    = mem_enable ? word_addr : 32'h0;
    assign mem_data_in    = issue_write ? gen_data : 32'h0;

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);
    assign pass = done && (error_count == '0);

endmodule

// File: tb/tb_sdram_mem_bist.sv
// Bench for sdram_mem_bist: ramio memory models with latency and fault
// injection, a request-sequence scoreboard and end-of-run result checks.
module tb_sdram_mem_bist;

    localparam int          WC_A = 16;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start_a = 1'b0;
    logic [3:0]  mask_a = 4'h0;
    logic        en_a, busy_a, done_a, pass_a;
    logic [1:0]  wt_a;
    logic [2:0]  rt_a;
    logic [31:0] addr_a, din_a, fea_a, fee_a, fac_a;
    logic [31:0] dout_a;
    logic        rdy_a, mbusy_a;
    logic [15:0] ecnt_a;

    logic        start_b = 1'b0;
    logic [3:0]  mask_b = 4'h0;
    logic        en_b, busy_b, done_b, pass_b;
    logic [1:0]  wt_b;
    logic [2:0]  rt_b;
    logic [31:0] addr_b, din_b, fea_b, fee_b, fac_b;
    logic [31:0] dout_b;
    logic        rdy_b;
    logic        mbusy_b;
    logic [3:0]  ecnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sdram_mem_bist #(
        .BaseAddress(32'h0), .WordCount(WC_A), .PatternCount(4),
        .LfsrSeed(SEED), .ErrorCountBitwidth(16)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .pattern_mask(mask_a),
        .mem_enable(en_a), .mem_write_type(wt_a), .mem_read_type(rt_a),
        .mem_address(addr_a), .mem_data_in(din_a), .mem_data_out(dout_a),
        .mem_data_out_ready(rdy_a), .mem_busy(mbusy_a), .busy(busy_a),
        .done(done_a), .pass(pass_a), .error_count(ecnt_a),
        .first_error_address(fea_a), .first_error_expected(fee_a),
        .first_error_actual(fac_a)
    );

    sdram_mem_bist #(
        .BaseAddress(32'h0), .WordCount(32), .PatternCount(4),
        .LfsrSeed(SEED), .ErrorCountBitwidth(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .pattern_mask(mask_b),
        .mem_enable(en_b), .mem_write_type(wt_b), .mem_read_type(rt_b),
        .mem_address(addr_b), .mem_data_in(din_b), .mem_data_out(dout_b),
        .mem_data_out_ready(rdy_b), .mem_busy(mbusy_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .error_count(ecnt_b),
        .first_error_address(fea_b), .first_error_expected(fee_b),
        .first_error_actual(fac_b)
    );

    // ---------------- memory model A: configurable busy time and a read fault
    logic [31:0] mem_a [logic [31:0]];
    int          lat_a = 0;
    int          cnt_a;
    logic        pend_a;
    logic [31:0] rd_addr_a;
    logic [31:0] f_addr = 32'hFFFF_FFFF;
    logic [31:0] f_and  = 32'hFFFF_FFFF;
    logic [31:0] f_or   = 32'h0;

    function automatic logic [31:0] fault_a(input logic [31:0] a, input logic [31:0] d);
        return (a == f_addr) ? ((d & f_and) | f_or) : d;
    endfunction

    function automatic logic [31:0] rd_mem_a(input logic [31:0] a);
        return mem_a.exists(a) ? fault_a(a, mem_a[a]) : 32'h0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mbusy_a   <= 1'b0;
            rdy_a     <= 1'b0;
            dout_a    <= 32'h0;
            cnt_a     <= 0;
            pend_a    <= 1'b0;
            rd_addr_a <= 32'h0;
        end else begin
            rdy_a <= 1'b0;
            if (cnt_a > 0) begin
                cnt_a <= cnt_a - 1;
                if (cnt_a == 1) begin
                    mbusy_a <= 1'b0;
                    if (pend_a) begin
                        rdy_a  <= 1'b1;
                        dout_a <= rd_mem_a(rd_addr_a);
                        pend_a <= 1'b0;
                    end
                end
            end else if (en_a) begin
                if (wt_a == 2'b11) mem_a[addr_a] = din_a;
                if (rt_a == 3'b111) begin
                    if (lat_a == 0) begin
                        rdy_a  <= 1'b1;
                        dout_a <= rd_mem_a(addr_a);
                    end else begin
                        pend_a    <= 1'b1;
                        rd_addr_a <= addr_a;
                    end
                end
                if (lat_a > 0) begin
                    mbusy_a <= 1'b1;
                    cnt_a   <= lat_a;
                end
            end
        end
    end

    // ---------------- memory model B: zero wait, bit 31 stuck at one everywhere
    logic [31:0] mem_b [logic [31:0]];
    assign mbusy_b = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_b  <= 1'b0;
            dout_b <= 32'h0;
        end else begin
            rdy_b <= 1'b0;
            if (en_b) begin
                if (wt_b == 2'b11) mem_b[addr_b] = din_b;
                if (rt_b == 3'b111) begin
                    rdy_b  <= 1'b1;
                    dout_b <= (mem_b.exists(addr_b) ? mem_b[addr_b] : 32'h0) | 32'h8000_0000;
                end
            end
        end
    end

    // ---------------- behavioural model of the expected request stream and result
    req_t        exp_q[$];
    req_t        wr_log[$];
    req_t        cmp_e;
    bit          chk_on = 1'b0;
    int          m_err;
    logic [31:0] m_fa, m_fe, m_fx;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [31:0] pat_word(input int p, input int i, input logic [31:0] lf);
        logic [31:0] a;
        a = 32'(i * 4);
        case (p)
            0:       return a;
            1:       return ~a;
            2:       return lf;
            default: return 32'd1 << (i % 32);
        endcase
    endfunction

    task automatic build(input logic [3:0] mask);
        logic [31:0] lf, d, act, a;
        exp_q.delete();
        wr_log.delete();
        m_err = 0; m_fa = 0; m_fe = 0; m_fx = 0;
        for (int p = 0; p < 4; p++) begin
            if (mask[p]) begin
                for (int ph = 0; ph < 2; ph++) begin
                    lf = SEED;
                    for (int i = 0; i < WC_A; i++) begin
                        a  = 32'(i * 4);
                        d  = pat_word(p, i, lf);
                        lf = lfsr_step(lf);
                        exp_q.push_back('{wr: (ph == 0), addr: a, data: d});
                        if (ph == 1) begin
                            act = fault_a(a, d);
                            if (act != d) begin
                                if (m_err == 0) begin
                                    m_fa = a; m_fe = d; m_fx = act;
                                end
                                if (m_err < 65535) m_err++;
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // ---------------- per-cycle request scoreboard for DUT A
    always @(negedge clk) begin
        if (chk_on && rst_n && en_a) begin
            n_cmp++;
            if (mbusy_a) begin
                n_bad++;
                $display("FAIL req_while_busy: request at %h while mem_busy=1, required none", addr_a);
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL extra_req: request at %h, required no further requests", addr_a);
            end else begin
                cmp_e = exp_q.pop_front();
                if (cmp_e.wr ? !(wt_a == 2'b11 && rt_a == 3'b000 && addr_a == cmp_e.addr && din_a == cmp_e.data)
                             : !(wt_a == 2'b00 && rt_a == 3'b111 && addr_a == cmp_e.addr)) begin
                    n_bad++;
                    $display("FAIL req: got wt=%b rt=%b addr=%h data=%h, required wr=%b addr=%h data=%h",
                             wt_a, rt_a, addr_a, din_a, cmp_e.wr, cmp_e.addr, cmp_e.data);
                end
            end
            if (wt_a == 2'b11) wr_log.push_back('{wr: 1'b1, addr: addr_a, data: din_a});
        end
    end

    task automatic launch(input logic [3:0] mask);
        @(negedge clk); #1;
        build(mask);
        mask_a  = mask;
        chk_on  = 1'b1;
        start_a = 1'b1;
        @(negedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int budget);
        int k;
        k = 0;
        while (!done_a && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, 32'(done_a), 32'd1);
        check({tag, "_pass"}, 32'(pass_a), 32'(m_err == 0));
        check({tag, "_busy"}, 32'(busy_a), 32'd0);
        check({tag, "_errcnt"}, 32'(ecnt_a), 32'(m_err));
        check({tag, "_fea"}, fea_a, m_fa);
        check({tag, "_fee"}, fee_a, m_fe);
        check({tag, "_fac"}, fac_a, m_fx);
        check({tag, "_reqs_left"}, 32'(exp_q.size()), 32'd0);
        chk_on = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"}, 32'(en_a), 32'd0);
        check({tag, "_wt"}, 32'(wt_a), 32'd0);
        check({tag, "_rt"}, 32'(rt_a), 32'd0);
        check({tag, "_addr"}, addr_a, 32'd0);
        check({tag, "_din"}, din_a, 32'd0);
        check({tag, "_busy"}, 32'(busy_a), 32'd0);
        check({tag, "_done"}, 32'(done_a), 32'd0);
        check({tag, "_pass"}, 32'(pass_a), 32'd0);
        check({tag, "_errcnt"}, 32'(ecnt_a), 32'd0);
        check({tag, "_fea"}, fea_a, 32'd0);
        check({tag, "_fee"}, fee_a, 32'd0);
        check({tag, "_fac"}, fac_a, 32'd0);
    endtask

    initial begin
        int k;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        #1 rst_n = 1'b1;

        // all four patterns, ideal memory
        launch(4'b1111);
        finish_run("all_patterns", 1000);
        check("wr_count", 32'(wr_log.size()), 32'd64);
        check("wr0_data", wr_log[0].data, 32'h0000_0000);
        check("wr15_addr", wr_log[15].addr, 32'h0000_003C);
        check("inv0_data", wr_log[16].data, 32'hFFFF_FFFF);
        check("lfsr0_data", wr_log[32].data, 32'hACE1_2468);
        check("lfsr1_data", wr_log[33].data, 32'h5670_9234);
        check("walk5_data", wr_log[53].data, 32'h0000_0020);

        // bit 5 stuck at zero at 0x20, address pattern only
        f_addr = 32'h20; f_and = ~32'h20; f_or = 32'h0;
        launch(4'b0001);
        finish_run("stuck_bit5", 500);
        check("stuck_errcnt_lit", 32'(ecnt_a), 32'd1);
        check("stuck_fea_lit", fea_a, 32'h20);
        check("stuck_fee_lit", fee_a, 32'h20);
        check("stuck_fac_lit", fac_a, 32'h0);
        f_addr = 32'hFFFF_FFFF; f_and = 32'hFFFF_FFFF;

        // empty mask: straight to done, clears the previous error record
        launch(4'b0000);
        finish_run("empty_mask", 1);

        // memory busy for 7 cycles after every request
        lat_a = 7;
        launch(4'b1111);
        finish_run("busy7", 5000);
        lat_a = 0;

        // saturating counter on the narrow instance
        @(negedge clk); #1;
        mask_b = 4'b0001; start_b = 1'b1;
        @(negedge clk); #1;
        start_b = 1'b0;
        k = 0;
        while (!done_b && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("sat_done", 32'(done_b), 32'd1);
        check("sat_busy", 32'(busy_b), 32'd0);
        check("sat_pass", 32'(pass_b), 32'd0);
        check("sat_errcnt", 32'(ecnt_b), 32'hF);
        check("sat_fea", fea_b, 32'h0);
        check("sat_fee", fee_b, 32'h0);
        check("sat_fac", fac_b, 32'h8000_0000);

        // asynchronous reset during the read phase, then a clean rerun
        launch(4'b1111);
        k = 0;
        while (rt_a != 3'b111 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("reached_read", 32'(rt_a), 32'h7);
        repeat (3) @(negedge clk);
        #2;
        chk_on = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        @(negedge clk); #1;
        rst_n = 1'b1;
        launch(4'b1111);
        finish_run("after_reset", 1000);

        // start pulse while busy must not disturb the run
        launch(4'b0011);
        repeat (20) @(negedge clk);
        #1;
        mask_a = 4'b1000; start_a = 1'b1;
        @(negedge clk); #1;
        start_a = 1'b0;
        finish_run("start_busy", 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sdram_mem_bist.md
Name: sdram_mem_bist

Overview:
- Hardware memory self-test engine. Replaces the firmware-driven memory test with a parametrised RTL sequencer.
- Master on the ramio word interface, so it sits between core and ramio: muxed in place of core, or on a second arbitration port.
- Writes then reads back a configurable address range with selectable data patterns.
- Reports pass/fail, a saturating error count and the first-failure snapshot.

Parameters:
- BaseAddress, 32'h0000_0000, byte address of the first tested word; must be 4-aligned.
- WordCount, 1024, number of 32-bit words tested per pattern; must be >= 1.
- PatternCount, 4, number of implemented patterns; at most 4.
- LfsrSeed, 32'hACE1_2468, seed for the LFSR pattern; must be non-zero.
- ErrorCountBitwidth, 16, width of the error counter.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse that starts a run; sampled only in Idle/Done.
- pattern_mask, in, PatternCount, bit p enables pattern p; sampled on start.
- mem_enable, out, 1, request valid.
- mem_write_type, out, 2, word write (WriteWord) or none.
- mem_read_type, out, 3, word read (ReadWord) or none.
- mem_address, out, 32, byte address.
- mem_data_in, out, 32, write data to ramio.
- mem_data_out, in, 32, read data from ramio.
- mem_data_out_ready, in, 1, read data valid.
- mem_busy, in, 1, ramio busy.
- busy, out, 1, run in progress.
- done, out, 1, high from end of run until the next start.
- pass, out, 1, valid when done: 1 if no errors.
- error_count, out, ErrorCountBitwidth, number of mismatches; saturates at all-ones.
- first_error_address, out, 32, address of the first mismatch.
- first_error_expected, out, 32, expected data at the first mismatch.
- first_error_actual, out, 32, read data at the first mismatch.

Behaviour:
- Reset: every output 0; FSM in Idle. Asynchronous reset mid-run drops mem_enable immediately; no pending state is kept.
- FSM states: Idle, Write, WriteWait, Read, ReadWait, NextPattern, Done.
- start in Idle/Done:
  - Latch pattern_mask; clear error_count and the first_error_* outputs; done=0, busy=1.
  - Select the lowest set pattern bit; go to Write.
  - If the mask is 0, go directly to Done with pass=1.
- start while busy is ignored.
- Word index i runs 0..WordCount-1. mem_address = BaseAddress + 4*i, 32-bit wrap.
- Patterns:
  - 0 = address.
  - 1 = ~address.
  - 2 = 32-bit Galois LFSR (taps 32,22,2,1) seeded with LfsrSeed at the start of each phase, stepped once per word, so the write and read sequences match.
  - 3 = walking one: 1 << (i mod 32).
- Write: when !mem_busy, assert mem_enable with mem_write_type=WriteWord and mem_read_type=none for exactly one cycle, then go to WriteWait. Requests are never issued while mem_busy is high.
- WriteWait: wait until mem_busy is low. At the last index, reset i and go to Read; otherwise increment i and go to Write.
- Read: when !mem_busy, one-cycle mem_enable with mem_read_type=ReadWord, then go to ReadWait.
- ReadWait: on mem_data_out_ready, compare against the expected data.
  - On mismatch, increment error_count (saturating).
  - If this is the first mismatch of the run, capture first_error_address/expected/actual.
  - At the last index go to NextPattern; otherwise increment i and go to Read.
- Only one request is outstanding at a time. mem_data_out_ready outside ReadWait is ignored.
- NextPattern: advance to the next set mask bit above the current one and return to Write with i=0; if none remain, go to Done.
- Done: busy=0, done=1, pass=(error_count==0). Outputs hold until the next start or reset.
- Cycle count for a zero-wait memory: 2 cycles per write; read time depends on ramio latency.

Decomposition:
- Package sdram_mem_bist_pkg holds:
  - state enum;
  - WriteWord=2'b11, WriteNone=2'b00, ReadWord=3'b111, ReadNone=3'b000;
  - pattern index constants;
  - LFSR tap mask constant.
- One sub-module, bist_pattern_gen (pattern index, word index, address, LFSR state → data and next LFSR), shared by the write and read phases.

Test Plan:
- Zero-wait ideal-memory model, WordCount=16, mask=4'b1111, start → mem_address sequence 0x0..0x3C written 4 times; done=1, pass=1, error_count=0.
- Model forces bit 5 stuck-at-0 at address 0x20, mask=4'b0001 → pass=0, error_count=1, first_error_address=0x20, expected=0x20, actual=0x00.
- mask=4'b0000 → done within 2 cycles, pass=1, mem_enable never asserted.
- mem_busy held high for 7 cycles after each request → no mem_enable while busy; final result pass=1.
- Stuck-at fault on every word, ErrorCountBitwidth=4, WordCount=32 → error_count saturates at 4'hF; first_error_* holds word 0.
- rst_n pulled low in the middle of the Read phase → mem_enable=0 and all outputs 0 asynchronously; a subsequent start runs cleanly to pass=1.
- start pulsed while busy → ignored; no change to the address sequence.
